// File: rtl/display_scan_mux_pkg.sv
// +----------------------------------------------------------------------------
// | display_scan_mux_pkg
// | Shared constants, types and helpers for the 7-segment display scanner.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package display_scan_mux_pkg;

  localparam logic [6:0] SEG_OFF          = 7'h7F;
  localparam int         DIGIT_IDX_W      = 3;
  localparam int         DEF_REFRESH_DIV  = 50000;
  localparam int         DEF_BLANK_CYCLES = 500;

  typedef logic [DIGIT_IDX_W-1:0] idx_t;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_e;

  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_mux_if.sv
// +----------------------------------------------------------------------------
// | display_scan_mux_if
// | Frame-load inputs and per-digit scan outputs of the display scanner.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface display_scan_mux_if #(
  parameter int N_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*N_DIGITS-1:0]   data_in;
  logic [N_DIGITS-1:0]     dp_in;
  logic                    lz_en;
  logic [3:0]              hex_out;
  logic                    blank_out;
  logic                    dp_out;
  logic [N_DIGITS-1:0]     an;
  logic [2:0]              digit_idx;
  logic                    frame_start;

  modport master (
    output en, load, data_in, dp_in, lz_en,
    input  hex_out, blank_out, dp_out, an, digit_idx, frame_start
  );

  modport slave (
    input  en, load, data_in, dp_in, lz_en,
    output hex_out, blank_out, dp_out, an, digit_idx, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/display_scan_mux_scan_timer.sv
// +----------------------------------------------------------------------------
// | display_scan_mux_scan_timer
// | Slot counter and digit index with look-ahead slot/frame/phase strobes.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module display_scan_mux_scan_timer
  import display_scan_mux_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output idx_t   digit_idx,
  output idx_t   idx_nxt,
  output logic   slot_start,
  output logic   frame_start_nxt,
  output logic   boundary,
  output phase_e phase_nxt
);

  localparam int                 c_cnt_w    = cnt_width(REFRESH_DIV);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_blank    = c_cnt_w'(BLANK_CYCLES);
  localparam idx_t               c_idx_last = idx_t'(N_DIGITS - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  idx_t               r_idx;
  logic               r_run;

  // r_run marks that the previous cycle was already scanning, so the first
  // enabled cycle restarts the frame at digit 0.
  always_comb begin : p_next
    w_cnt_nxt       = r_cnt + 1'b1;
    idx_nxt         = r_idx;
    slot_start      = 1'b0;
    frame_start_nxt = 1'b0;
    boundary        = 1'b0;
    if (!en) begin
      w_cnt_nxt = '0;
      idx_nxt   = '0;
    end else if (!r_run) begin
      w_cnt_nxt       = '0;
      idx_nxt         = '0;
      slot_start      = 1'b1;
      frame_start_nxt = 1'b1;
    end else if (r_cnt == c_cnt_last) begin
      w_cnt_nxt  = '0;
      slot_start = 1'b1;
      if (r_idx == c_idx_last) begin
        idx_nxt         = '0;
        boundary        = 1'b1;
        frame_start_nxt = 1'b1;
      end else begin
        idx_nxt = r_idx + 1'b1;
      end
    end
    phase_nxt = (w_cnt_nxt >= c_blank) ? PH_ON : PH_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_reg
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_run <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= idx_nxt;
      r_run <= en;
    end
  end

  assign digit_idx = r_idx;

endmodule

`default_nettype wire

// File: rtl/display_scan_mux.sv
// +----------------------------------------------------------------------------
// | display_scan_mux
// | Time-multiplexed N-digit 7-segment scanner with tear-free frame loading.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int REFRESH_DIV   = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES  = DEF_BLANK_CYCLES,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scan_mux_if.slave   bus
);

  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_chk_ndigits
    $error("display_scan_mux: N_DIGITS must be in 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_chk_div
    $error("display_scan_mux: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_chk_blank
    $error("display_scan_mux: BLANK_CYCLES must be in 0..REFRESH_DIV-1");
  end

  localparam logic [N_DIGITS-1:0] c_an_off = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : '0;

  idx_t   w_idx_nxt;
  logic   w_slot_start;
  logic   w_frame_start_nxt;
  logic   w_boundary;
  phase_e w_phase_nxt;

  display_scan_mux_scan_timer #(
    .N_DIGITS     (N_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (bus.en),
    .digit_idx       (bus.digit_idx),
    .idx_nxt         (w_idx_nxt),
    .slot_start      (w_slot_start),
    .frame_start_nxt (w_frame_start_nxt),
    .boundary        (w_boundary),
    .phase_nxt       (w_phase_nxt)
  );

  logic [4*N_DIGITS-1:0] r_shadow, r_pend, w_shadow_nxt, w_pend_nxt;
  logic [N_DIGITS-1:0]   r_shadow_dp, r_pend_dp, w_shadow_dp_nxt, w_pend_dp_nxt;
  logic                  r_pending, w_pending_nxt;
  logic [3:0]            w_nib;
  logic                  w_dp, w_lz;
  logic [N_DIGITS-1:0]   w_sel, w_an_on;
  logic [3:0]            r_hex;
  logic                  r_blank, r_dp, r_fs;
  logic [N_DIGITS-1:0]   r_an;

  // Loads while scanning are parked in pend_buf and only reach the shadow at
  // the frame boundary; a load in the boundary cycle itself goes straight in.
  always_comb begin : p_frame
    w_shadow_nxt    = r_shadow;
    w_shadow_dp_nxt = r_shadow_dp;
    w_pend_nxt      = r_pend;
    w_pend_dp_nxt   = r_pend_dp;
    w_pending_nxt   = r_pending;
    if (!bus.en) begin
      if (bus.load) begin
        w_shadow_nxt    = bus.data_in;
        w_shadow_dp_nxt = bus.dp_in;
        w_pending_nxt   = 1'b0;
      end
    end else if (w_boundary) begin
      w_pending_nxt = 1'b0;
      if (bus.load) begin
        w_shadow_nxt    = bus.data_in;
        w_shadow_dp_nxt = bus.dp_in;
      end else if (r_pending) begin
        w_shadow_nxt    = r_pend;
        w_shadow_dp_nxt = r_pend_dp;
      end
    end else if (bus.load) begin
      w_pend_nxt    = bus.data_in;
      w_pend_dp_nxt = bus.dp_in;
      w_pending_nxt = 1'b1;
    end
  end

  // Walk from the MSD down so v_zero means "this digit and all above are 0".
  always_comb begin : p_digit
    logic v_zero;
    v_zero = 1'b1;
    w_nib  = 4'h0;
    w_dp   = 1'b0;
    w_lz   = 1'b0;
    w_sel  = '0;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      v_zero = v_zero & (w_shadow_nxt[4*d +: 4] == 4'h0);
      if (w_idx_nxt == idx_t'(d)) begin
        w_nib    = w_shadow_nxt[4*d +: 4];
        w_dp     = w_shadow_dp_nxt[d];
        w_lz     = v_zero & (d > 0);
        w_sel[d] = 1'b1;
      end
    end
  end

  assign w_an_on = AN_ACTIVE_LOW ? ~w_sel : w_sel;

  always_ff @(posedge clk or negedge rst_n) begin : p_reg
    if (!rst_n) begin
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_pend      <= '0;
      r_pend_dp   <= '0;
      r_pending   <= 1'b0;
      r_hex       <= 4'h0;
      r_blank     <= 1'b1;
      r_dp        <= 1'b0;
      r_fs        <= 1'b0;
      r_an        <= c_an_off;
    end else begin
      r_shadow    <= w_shadow_nxt;
      r_shadow_dp <= w_shadow_dp_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_dp   <= w_pend_dp_nxt;
      r_pending   <= w_pending_nxt;
      r_fs        <= w_frame_start_nxt;
      r_an        <= (bus.en && w_phase_nxt == PH_ON) ? w_an_on : c_an_off;
      if (!bus.en) begin
        r_blank <= 1'b1;
      end else if (w_slot_start) begin
        r_hex   <= w_nib;
        r_dp    <= w_dp;
        r_blank <= bus.lz_en & w_lz;
      end
    end
  end

  assign bus.hex_out     = r_hex;
  assign bus.blank_out   = r_blank;
  assign bus.dp_out      = r_dp;
  assign bus.an          = r_an;
  assign bus.frame_start = r_fs;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_mux.sv
// +----------------------------------------------------------------------------
// | tb_display_scan_mux
// | Scoreboard bench: expected per-slot digits queued at load, checked per slot.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_display_scan_mux;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  display_scan_mux_if #(.N_DIGITS(N)) bus ();

  display_scan_mux #(
    .N_DIGITS      (N),
    .REFRESH_DIV   (DIV),
    .BLANK_CYCLES  (BLK),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic [3:0] hex;
    logic       blank;
    logic       dp;
  } slot_t;

  slot_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] data, input logic [3:0] dp, input logic lz);
    slot_t e;
    for (int d = 0; d < N; d++) begin
      e.idx   = 3'(d);
      e.hex   = data[4*d +: 4];
      e.blank = lz && (d > 0) && ((data >> (4*d)) == 16'h0);
      e.dp    = dp[d];
      sb_q.push_back(e);
    end
  endtask

  task automatic drive_load(input logic [15:0] data, input logic [3:0] dp);
    bus.load    = 1'b1;
    bus.data_in = data;
    bus.dp_in   = dp;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, " an"},          bus.an,          4'hF);
    check({pfx, " hex"},         bus.hex_out,     4'h0);
    check({pfx, " blank"},       bus.blank_out,   1'b1);
    check({pfx, " dp"},          bus.dp_out,      1'b0);
    check({pfx, " idx"},         bus.digit_idx,   3'd0);
    check({pfx, " frame_start"}, bus.frame_start, 1'b0);
  endtask

  task automatic wait_frame(output int lat);
    logic found;
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 64 && !found; i++) begin
      @(negedge clk);
      if (bus.frame_start) begin
        found = 1'b1;
        lat   = i;
      end
    end
    check("frame_start_seen", found, 1'b1);
  endtask

  // Entered on the negedge of the first cycle of a frame; leaves on the
  // negedge of the first cycle of the following frame.
  task automatic run_frame();
    slot_t      e;
    logic [3:0] exp_an;
    for (int s = 0; s < N; s++) begin
      for (int c = 0; c < DIV; c++) begin
        exp_an = (c < BLK) ? 4'hF : ~(4'b0001 << s);
        check($sformatf("idx s%0d c%0d", s, c), bus.digit_idx, s);
        check($sformatf("an s%0d c%0d", s, c), bus.an, exp_an);
        check($sformatf("fs s%0d c%0d", s, c), bus.frame_start, (s == 0 && c == 0));
        if (c == 0) begin
          if (sb_q.size() == 0) begin
            check("sb_depth", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("slot idx d%0d", s), bus.digit_idx, e.idx);
            check($sformatf("hex d%0d", s),      bus.hex_out,   e.hex);
            check($sformatf("blank d%0d", s),    bus.blank_out, e.blank);
            check($sformatf("dp d%0d", s),       bus.dp_out,    e.dp);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    bus.en      = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = '0;
    bus.dp_in   = '0;
    bus.lz_en   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Frame loaded while dark, then scanning starts
    @(negedge clk);
    drive_load(16'h1234, 4'b0000);
    check("dark an",    bus.an,        4'hF);
    check("dark blank", bus.blank_out, 1'b1);
    push_frame(16'h1234, 4'b0000, 1'b0);
    bus.en = 1'b1;
    wait_frame(lat);
    check("start latency", lat, 1);
    run_frame();

    // Leading-zero blanking, loaded mid-frame
    push_frame(16'h1234, 4'b0000, 1'b0);
    fork
      run_frame();
      begin
        repeat (11) @(negedge clk);
        bus.lz_en = 1'b1;
        push_frame(16'h0050, 4'b1100, 1'b1);
        drive_load(16'h0050, 4'b1100);
      end
    join
    run_frame();
    bus.lz_en = 1'b0;
    push_frame(16'h0050, 4'b1100, 1'b0);
    run_frame();

    // Two mid-frame loads: current frame untouched, last load wins
    push_frame(16'h0050, 4'b1100, 1'b0);
    fork
      run_frame();
      begin
        repeat (11) @(negedge clk);
        drive_load(16'hABCD, 4'b0000);
        repeat (8) @(negedge clk);
        push_frame(16'hBEEF, 4'b0000, 1'b0);
        drive_load(16'hBEEF, 4'b0000);
      end
    join

    // Load in the very last cycle of the digit-3 slot
    fork
      run_frame();
      begin
        repeat (31) @(negedge clk);
        push_frame(16'h9999, 4'b0000, 1'b0);
        drive_load(16'h9999, 4'b0000);
      end
    join
    run_frame();

    // en dropped mid-slot, direct load while dark, then restart
    repeat (10) @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("off an",    bus.an,          4'hF);
      check("off blank", bus.blank_out,   1'b1);
      check("off idx",   bus.digit_idx,   3'd0);
      check("off fs",    bus.frame_start, 1'b0);
    end
    bus.lz_en = 1'b1;
    drive_load(16'h0007, 4'b0001);
    check("off blank after load", bus.blank_out, 1'b1);
    push_frame(16'h0007, 4'b0001, 1'b1);
    bus.en = 1'b1;
    wait_frame(lat);
    check("restart latency", lat, 1);
    run_frame();

    // Asynchronous reset pulse between edges during an ON phase
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async rst");
    #1 rst_n = 1'b1;
    push_frame(16'h0000, 4'b0000, 1'b1);
    wait_frame(lat);
    check("post-reset latency", lat, 1);
    run_frame();

    check("sb drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
